// File: rtl/dbg_pkg.sv
// Shared constants for the debug mailbox: command codes, FSM states and
// status word indices.
package dbg_pkg;

  localparam logic [31:0] CMD_EXIT   = 32'h0000_0000;
  localparam logic [31:0] CMD_EQ     = 32'h0000_0001;
  localparam logic [31:0] CMD_NE     = 32'h0000_0002;
  localparam logic [31:0] CMD_MEQ    = 32'h0000_0003;
  localparam logic [31:0] CMD_LTU    = 32'h0000_0004;
  localparam logic [31:0] CMD_REGCHK = 32'h0001_0000;
  localparam logic [31:0] CMD_DUMP   = 32'hFFFF_0000;
  localparam logic [31:0] CMD_NONE   = 32'hFFFF_FFFF;

  // arg1 value that tells the bench to skip gp/sp in the register check
  localparam logic [31:0] REGCHK_IGNORE_GP_SP = 32'h0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int STAT_PASS = 0;
  localparam int STAT_FAIL = 1;
  localparam int STAT_SEQ  = 2;
  localparam int STAT_CTRL = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding the fail log; a pop in the same cycle frees a
// slot for a push when full, and a rejected push is flagged on o_drop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != '0);
  assign w_push_ok = i_push && ((r_count != (PW+1)'(DEPTH)) || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;
  assign o_valid   = (r_count != '0);
  assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/dbg_mailbox.sv
// Debug mailbox: software writes args then a command word; the command is
// evaluated in one stall cycle, updating pass/fail counters and the fail log.
module dbg_mailbox
  import dbg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ARG_WORDS = 8,
  parameter int LOG_DEPTH = 4,
  parameter int SEQ_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [$clog2(ARG_WORDS):0]   addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         stall,
  output logic                         halt,
  output logic                         regchk_req,
  output logic                         regchk_ignore_gp_sp,
  output logic                         dump_req,
  output logic                         fail_valid,
  input  logic                         fail_pop,
  output logic [SEQ_W-1:0]             fail_seq,
  output logic [SEQ_W-1:0]             pass_count,
  output logic [SEQ_W-1:0]             fail_count
);

  localparam int IW = $clog2(ARG_WORDS);

  function automatic logic [SEQ_W-1:0] sat_inc(input logic [SEQ_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_mbox [ARG_WORDS];
  logic [SEQ_W-1:0]   r_pass;
  logic [SEQ_W-1:0]   r_fail;
  logic [SEQ_W-1:0]   r_seq;
  logic               r_ovf;
  logic               r_regchk;
  logic               r_dump;
  logic [DATA_W-1:0]  r_rdata;

  logic [IW-1:0]      w_idx;
  logic               w_wr_ok;
  logic               w_cmd_wr;
  logic               w_eval;
  logic               w_is_check;
  logic               w_pass;
  logic               w_push;
  logic               w_drop;
  logic [DATA_W-1:0]  w_cmd;
  logic [DATA_W-1:0]  w_a1;
  logic [DATA_W-1:0]  w_a2;
  logic [DATA_W-1:0]  w_a3;
  logic [DATA_W-1:0]  w_stat;

  assign w_idx    = addr[IW-1:0];
  assign w_wr_ok  = we && !addr[IW] && (r_state == ST_IDLE);
  assign w_cmd_wr = w_wr_ok && (w_idx == '0);
  assign w_eval   = (r_state == ST_EVAL);
  assign w_cmd    = r_mbox[0];
  assign w_a1     = r_mbox[1];
  assign w_a2     = r_mbox[2];
  assign w_a3     = r_mbox[3];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_cmd_wr) w_state_nxt = ST_EVAL;
      ST_EVAL:   w_state_nxt = (w_cmd == DATA_W'(CMD_EXIT)) ? ST_HALTED : ST_IDLE;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_is_check = 1'b1;
    w_pass     = 1'b0;
    case (w_cmd)
      DATA_W'(CMD_EQ):  w_pass = (w_a1 == w_a2);
      DATA_W'(CMD_NE):  w_pass = (w_a1 != w_a2);
      DATA_W'(CMD_MEQ): w_pass = ((w_a1 & w_a3) == (w_a2 & w_a3));
      DATA_W'(CMD_LTU): w_pass = (w_a1 < w_a2);
      DATA_W'(CMD_EXIT), DATA_W'(CMD_REGCHK), DATA_W'(CMD_DUMP): w_is_check = 1'b0;
      default:          w_pass = 1'b0;
    endcase
  end

  assign w_push = w_eval && w_is_check && !w_pass;

  // Fail-log entries carry the sequence number this check is assigned
  sync_fifo #(.WIDTH(SEQ_W), .DEPTH(LOG_DEPTH)) u_fail_log (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (sat_inc(r_seq)),
    .i_pop   (fail_pop),
    .o_data  (fail_seq),
    .o_valid (fail_valid),
    .o_drop  (w_drop)
  );

  always_comb begin
    w_stat = '0;
    if      (w_idx == IW'(STAT_PASS)) w_stat = DATA_W'(r_pass);
    else if (w_idx == IW'(STAT_FAIL)) w_stat = DATA_W'(r_fail);
    else if (w_idx == IW'(STAT_SEQ))  w_stat = DATA_W'(r_seq);
    else if (w_idx == IW'(STAT_CTRL)) w_stat = DATA_W'({r_ovf, halt, r_state});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      for (int i = 1; i < ARG_WORDS; i++) r_mbox[i] <= '0;
      r_mbox[0] <= DATA_W'(CMD_NONE);
      r_pass   <= '0;
      r_fail   <= '0;
      r_seq    <= '0;
      r_ovf    <= 1'b0;
      r_regchk <= 1'b0;
      r_dump   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_ok) r_mbox[w_idx] <= wdata;
      r_regchk <= w_eval && (w_cmd == DATA_W'(CMD_REGCHK));
      r_dump   <= w_eval && (w_cmd == DATA_W'(CMD_DUMP));
      if (w_eval && w_is_check) begin
        r_seq <= sat_inc(r_seq);
        if (w_pass) r_pass <= sat_inc(r_pass);
        else        r_fail <= sat_inc(r_fail);
      end
      if (w_drop) r_ovf <= 1'b1;
      r_rdata <= addr[IW] ? w_stat : r_mbox[w_idx];
    end
  end

  assign rdata               = r_rdata;
  assign stall               = w_eval;
  assign halt                = (r_state == ST_HALTED);
  assign regchk_req          = r_regchk;
  assign dump_req            = r_dump;
  assign regchk_ignore_gp_sp = (w_a1 == DATA_W'(REGCHK_IGNORE_GP_SP));
  assign pass_count          = r_pass;
  assign fail_count          = r_fail;

endmodule

// File: tb/tb_dbg_mailbox.sv
// Randomised bench for dbg_mailbox against a queue-based reference model of
// the mailbox command semantics.
module tb_dbg_mailbox;

  localparam int DW = 32;
  localparam int NW = 8;
  localparam int LD = 2;
  localparam int SW = 16;
  localparam int AW = 4;

  localparam logic [31:0] C_EXIT   = 32'h0000_0000;
  localparam logic [31:0] C_EQ     = 32'h0000_0001;
  localparam logic [31:0] C_MEQ    = 32'h0000_0003;
  localparam logic [31:0] C_LTU    = 32'h0000_0004;
  localparam logic [31:0] C_REGCHK = 32'h0001_0000;
  localparam logic [31:0] C_DUMP   = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic reset, we, fail_pop;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic stall, halt, regchk_req, regchk_ignore_gp_sp, dump_req, fail_valid;
  logic [SW-1:0] fail_seq, pass_count, fail_count;

  always #5 clk = ~clk;

  dbg_mailbox #(.DATA_W(DW), .ARG_WORDS(NW), .LOG_DEPTH(LD), .SEQ_W(SW)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .halt(halt), .regchk_req(regchk_req),
    .regchk_ignore_gp_sp(regchk_ignore_gp_sp), .dump_req(dump_req),
    .fail_valid(fail_valid), .fail_pop(fail_pop), .fail_seq(fail_seq),
    .pass_count(pass_count), .fail_count(fail_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_arg [NW];
  int          m_pass, m_fail, m_seq;
  bit          m_ovf, m_halt;
  int          m_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NW; i++) m_arg[i] = 32'h0;
    m_arg[0] = 32'hFFFF_FFFF;
    m_pass = 0; m_fail = 0; m_seq = 0;
    m_ovf = 1'b0; m_halt = 1'b0;
    m_q.delete();
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic wr_arg(input int k, input logic [31:0] d);
    wr(AW'(k), d);
    if (!m_halt) m_arg[k] = d;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    addr = a;
    tick();
    check(tag, 64'(rdata), 64'(exp));
  endtask

  task automatic chk_ctrl(input string tag);
    addr = {1'b1, 3'd3};
    tick();
    check(tag, 64'(rdata[31:2]), 64'({m_ovf, m_halt}));
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pass"}, 64'(pass_count), 64'(m_pass));
    check({tag, ".fail"}, 64'(fail_count), 64'(m_fail));
    check({tag, ".fvalid"}, 64'(fail_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) check({tag, ".fseq"}, 64'(fail_seq), 64'(m_q[0]));
    check({tag, ".halt"}, 64'(halt), 64'(m_halt));
  endtask

  task automatic do_cmd(input logic [31:0] c, input bit pop_during, input bit stall_wr);
    bit ok, exp_reg, exp_dump, exp_ign;
    wr(AW'(0), c);
    if (m_halt) begin
      check("stall_halted", 64'(stall), 64'(0));
      tick();
      check("pulse_halted", 64'({regchk_req, dump_req}), 64'(0));
    end else begin
      check("stall_hi", 64'(stall), 64'(1));
      fail_pop = pop_during;
      if (stall_wr) begin
        we = 1'b1; addr = AW'(2); wdata = 32'hDEAD_BEEF;
      end
      tick();
      fail_pop = 1'b0; we = 1'b0;
      if (pop_during && m_q.size() > 0) void'(m_q.pop_front());
      m_arg[0] = c;
      exp_reg = 1'b0; exp_dump = 1'b0;
      exp_ign = (m_arg[1] == 32'h0001_0000);
      if (c == C_EXIT) m_halt = 1'b1;
      else if (c == C_REGCHK) exp_reg = 1'b1;
      else if (c == C_DUMP) exp_dump = 1'b1;
      else begin
        case (c)
          32'd1:   ok = (m_arg[1] == m_arg[2]);
          32'd2:   ok = (m_arg[1] != m_arg[2]);
          32'd3:   ok = ((m_arg[1] & m_arg[3]) == (m_arg[2] & m_arg[3]));
          32'd4:   ok = (m_arg[1] < m_arg[2]);
          default: ok = 1'b0;
        endcase
        m_seq = sat(m_seq);
        if (ok) m_pass = sat(m_pass);
        else begin
          m_fail = sat(m_fail);
          if (m_q.size() < LD) m_q.push_back(m_seq);
          else m_ovf = 1'b1;
        end
      end
      check("stall_lo", 64'(stall), 64'(0));
      check("regchk_req", 64'(regchk_req), 64'(exp_reg));
      check("dump_req", 64'(dump_req), 64'(exp_dump));
      if (exp_reg) check("regchk_ign", 64'(regchk_ignore_gp_sp), 64'(exp_ign));
      tick();
      check("pulse_end", 64'({regchk_req, dump_req}), 64'(0));
    end
    check_state("cmd");
  endtask

  task automatic do_pop();
    if (m_q.size() > 0) begin
      check("pop_seq", 64'(fail_seq), 64'(m_q[0]));
      void'(m_q.pop_front());
    end
    fail_pop = 1'b1;
    tick();
    fail_pop = 1'b0;
    check_state("pop");
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h5;
      2:       return 32'h6;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0001_0000;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] rnd_cmd();
    case ($urandom_range(0, 7))
      0:       return 32'd1;
      1:       return 32'd2;
      2:       return 32'd3;
      3:       return 32'd4;
      4:       return C_REGCHK;
      5:       return C_DUMP;
      6:       return 32'hFFFF_FFFF;
      default: return 32'h100 + 32'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    reset = 1'b1; we = 1'b0; fail_pop = 1'b0; addr = '0; wdata = '0;
    m_reset();
    tick(); tick();
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_pulses", 64'({regchk_req, dump_req}), 64'(0));
    check_state("rst");
    reset = 1'b0;
    rd_chk("rst_word0", AW'(0), 32'hFFFF_FFFF);
    rd_chk("rst_word1", AW'(1), 32'h0);

    wr_arg(1, 32'h1234); wr_arg(2, 32'h1234);
    do_cmd(C_EQ, 1'b0, 1'b0);
    check("eq_pass_cnt", 64'(pass_count), 64'(1));
    check("eq_fvalid", 64'(fail_valid), 64'(0));
    rd_chk("eq_seq", {1'b1, 3'd2}, 32'd1);
    rd_chk("wr_readback", AW'(2), 32'h1234);

    wr_arg(1, 32'd5); wr_arg(2, 32'd6);
    for (int i = 0; i < 3; i++) do_cmd(C_EQ, 1'b0, 1'b0);
    check("fail3_cnt", 64'(fail_count), 64'(3));
    chk_ctrl("ovf_set");
    check("ovf_bit", 64'(rdata[3]), 64'(1));
    do_pop();
    do_pop();
    do_pop();

    wr_arg(1, 32'hFF00_12AB); wr_arg(2, 32'h0000_12CD); wr_arg(3, 32'h0000_FF00);
    do_cmd(C_MEQ, 1'b0, 1'b0);
    check("meq_pass", 64'(pass_count), 64'(2));
    wr_arg(1, 32'hFFFF_FFFF); wr_arg(2, 32'd1);
    do_cmd(C_LTU, 1'b0, 1'b0);
    check("ltu_fail", 64'(fail_count), 64'(4));

    wr_arg(1, 32'h0001_0000);
    do_cmd(C_REGCHK, 1'b0, 1'b0);
    do_cmd(C_DUMP, 1'b0, 1'b0);

    wr_arg(2, 32'h0000_0042);
    do_cmd(C_EQ, 1'b0, 1'b1);
    rd_chk("stall_wr_ignored", AW'(2), m_arg[2]);

    // reset asserted while the command is being evaluated
    wr_arg(1, 32'd7); wr_arg(2, 32'd7);
    wr(AW'(0), C_EQ);
    check("rst_eval_stall", 64'(stall), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_reset();
    check_state("rst_eval");
    rd_chk("rst_eval_seq", {1'b1, 3'd2}, 32'd0);

    // full FIFO with pop and push on the same edge
    wr_arg(1, 32'd5); wr_arg(2, 32'd6);
    do_cmd(C_EQ, 1'b0, 1'b0);
    do_cmd(C_EQ, 1'b0, 1'b0);
    do_cmd(C_EQ, 1'b1, 1'b0);
    chk_ctrl("simul_ovf");
    check("simul_fseq", 64'(fail_seq), 64'(2));
    do_pop();
    do_pop();
    do_pop();

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 5))
        0, 1:    wr_arg($urandom_range(1, 3), rnd_val());
        2, 3:    do_cmd(rnd_cmd(), ($urandom_range(0, 3) == 0), 1'b0);
        4:       do_pop();
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            int k;
            k = $urandom_range(0, NW - 1);
            rd_chk("rand_arg", AW'(k), m_arg[k]);
          end else begin
            rd_chk("rand_seq", {1'b1, 3'd2}, 32'(m_seq));
            chk_ctrl("rand_ctrl");
          end
        end
      endcase
    end

    do_cmd(C_EXIT, 1'b0, 1'b0);
    check("exit_halt", 64'(halt), 64'(1));
    wr_arg(2, 32'h0000_0077);
    do_cmd(C_EQ, 1'b0, 1'b0);
    rd_chk("halt_arg", AW'(2), m_arg[2]);
    rd_chk("halt_cmd", AW'(0), 32'h0);
    chk_ctrl("halt_ctrl");

    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_reset();
    check("unhalt", 64'(halt), 64'(0));
    rd_chk("unhalt_word0", AW'(0), 32'hFFFF_FFFF);
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
